// File: rtl/r_cpu_multicycle.sv
// Multi-cycle MIPS R-type core: IF -> ID -> EX -> WB over a valid/ready fetch port, plus a register-file debug port.
// Optional OVF_TRAP_EN: an overflowing ADD/SUB skips its writeback and sets a sticky trap output.
module r_cpu_multicycle #(
  parameter int DATA_W  = 32,
  parameter int REG_N   = 32,
  parameter int PC_W    = 32,
  parameter int PC_STEP = 4
) (
  input  logic              CLK,
  input  logic              RST,
  output logic [PC_W-1:0]   PC,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [31:0]       Inst_code,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [3:0]        ALU_OP,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] F,
  output logic              ZF,
  output logic              OF,
  output logic              illegal,
  input  logic              dbg_we,
  input  logic [4:0]        dbg_addr,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out
`ifdef OVF_TRAP_EN
  ,
  output logic              trap
`endif
);

  localparam int RI_W = $clog2(REG_N);
  localparam int SH_W = (DATA_W > 32) ? 5 : $clog2(DATA_W);

  typedef enum logic [1:0] {S_IF, S_ID, S_EX, S_WB} state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_ILL = 4'hF;

  state_t                        state_q, state_d;
  logic [PC_W-1:0]               pc_q, pc_d;
  logic [31:0]                   inst_q, inst_d;
  logic [3:0]                    aluop_q, aluop_d;
  logic [DATA_W-1:0]             a_q, a_d, b_q, b_d, f_q, f_d;
  logic                          zf_q, zf_d, of_q, of_d, ill_q, ill_d;
  logic [REG_N-1:0][DATA_W-1:0]  regs_q, regs_d;
`ifdef OVF_TRAP_EN
  logic                          trap_q, trap_d;
`endif

  logic [RI_W-1:0]   rs_idx, rt_idx, rd_idx, dbg_idx;
  logic [SH_W-1:0]   shamt;
  logic [3:0]        dec_op;
  logic [DATA_W-1:0] res;
  logic              ovf, ex_ill, wr_en;

  assign rs_idx  = inst_q[21 +: RI_W];
  assign rt_idx  = inst_q[16 +: RI_W];
  assign rd_idx  = inst_q[11 +: RI_W];
  assign dbg_idx = dbg_addr[RI_W-1:0];
  assign shamt   = inst_q[6 +: SH_W];

  always_comb begin
    case (inst_q[5:0])
      6'h20:   dec_op = OP_ADD;
      6'h22:   dec_op = OP_SUB;
      6'h24:   dec_op = OP_AND;
      6'h25:   dec_op = OP_OR;
      6'h26:   dec_op = OP_XOR;
      6'h27:   dec_op = OP_NOR;
      6'h2A:   dec_op = OP_SLT;
      6'h00:   dec_op = OP_SLL;
      6'h02:   dec_op = OP_SRL;
      default: dec_op = OP_ILL;
    endcase
  end

  // Illegal instructions carry a zero result so F/ZF/OF stay well defined.
  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (aluop_q)
      OP_ADD: begin
        res = a_q + b_q;
        ovf = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (res[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_SUB: begin
        res = a_q - b_q;
        ovf = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (res[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_AND:  res = a_q & b_q;
      OP_OR:   res = a_q | b_q;
      OP_XOR:  res = a_q ^ b_q;
      OP_NOR:  res = ~(a_q | b_q);
      OP_SLT:  res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLL:  res = b_q << shamt;
      OP_SRL:  res = b_q >> shamt;
      default: res = '0;
    endcase
    ex_ill = (inst_q[31:26] != 6'd0) || (aluop_q == OP_ILL);
    if (ex_ill) begin
      res = '0;
      ovf = 1'b0;
    end
  end

`ifdef OVF_TRAP_EN
  assign wr_en = !ill_q && (rd_idx != '0) && !of_q;
`else
  assign wr_en = !ill_q && (rd_idx != '0);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    aluop_d = aluop_q;
    a_d     = a_q;
    b_d     = b_q;
    f_d     = f_q;
    zf_d    = zf_q;
    of_d    = of_q;
    ill_d   = 1'b0;
    regs_d  = regs_q;
`ifdef OVF_TRAP_EN
    trap_d  = trap_q;
`endif
    // Debug write first so a same-cycle WB to the same register overrides it.
    if (dbg_we && dbg_idx != '0) regs_d[dbg_idx] = in;
    case (state_q)
      S_IF: if (inst_valid) begin
        inst_d  = Inst_code;
        state_d = S_ID;
      end
      S_ID: begin
        a_d     = regs_q[rs_idx];
        b_d     = regs_q[rt_idx];
        aluop_d = dec_op;
        state_d = S_EX;
      end
      S_EX: begin
        f_d     = res;
        zf_d    = (res == '0);
        of_d    = ovf;
        ill_d   = ex_ill;
        state_d = S_WB;
      end
      default: begin
        if (wr_en) regs_d[rd_idx] = f_q;
`ifdef OVF_TRAP_EN
        trap_d  = trap_q | of_q;
`endif
        pc_d    = pc_q + PC_W'(PC_STEP);
        state_d = S_IF;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IF;
      pc_q    <= '0;
      inst_q  <= '0;
      aluop_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      zf_q    <= 1'b0;
      of_q    <= 1'b0;
      ill_q   <= 1'b0;
      regs_q  <= '0;
`ifdef OVF_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      aluop_q <= aluop_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      zf_q    <= zf_d;
      of_q    <= of_d;
      ill_q   <= ill_d;
      regs_q  <= regs_d;
`ifdef OVF_TRAP_EN
      trap_q  <= trap_d;
`endif
    end
  end

  assign PC         = pc_q;
  assign inst_ready = (state_q == S_IF);
  assign rs         = inst_q[25:21];
  assign rt         = inst_q[20:16];
  assign rd         = inst_q[15:11];
  assign ALU_OP     = aluop_q;
  assign A          = a_q;
  assign B          = b_q;
  assign F          = f_q;
  assign ZF         = zf_q;
  assign OF         = of_q;
  assign illegal    = ill_q;
  assign out        = (dbg_idx == '0) ? '0 : regs_q[dbg_idx];
`ifdef OVF_TRAP_EN
  assign trap       = trap_q;
`endif

endmodule

// File: tb/tb_r_cpu_multicycle.sv
// Bench for r_cpu_multicycle: directed scenarios plus random R-type traffic checked against an
// instruction-level model; a negedge process compares all visible state every cycle.
module tb_r_cpu_multicycle;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] PC;
  logic        inst_valid, inst_ready;
  logic [31:0] Inst_code;
  logic [4:0]  rs, rt, rd;
  logic [3:0]  ALU_OP;
  logic [31:0] A, B, F;
  logic        ZF, OF, illegal;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] din, dout;
`ifdef OVF_TRAP_EN
  logic        trap;
`endif

  always #5 CLK = ~CLK;

  r_cpu_multicycle #(.DATA_W(32), .REG_N(32), .PC_W(32), .PC_STEP(4)) dut (
    .CLK(CLK), .RST(RST), .PC(PC), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .Inst_code(Inst_code), .rs(rs), .rt(rt), .rd(rd), .ALU_OP(ALU_OP),
    .A(A), .B(B), .F(F), .ZF(ZF), .OF(OF), .illegal(illegal),
`ifdef OVF_TRAP_EN
    .trap(trap),
`endif
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .in(din), .out(dout)
  );

  // Architectural model
  logic [31:0] mreg [32];
  logic [31:0] mpc, ma, mb, mf, m_inst;
  logic        mzf, mof, mtrap, exp_ready, exp_ill;
  bit          chk_en = 1'b0;
  int          n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) if (chk_en) begin
    chk("pc", PC, mpc);
    chk("inst_ready", inst_ready, exp_ready);
    chk("illegal", illegal, exp_ill);
    chk("rs", rs, m_inst[25:21]);
    chk("rt", rt, m_inst[20:16]);
    chk("rd", rd, m_inst[15:11]);
    chk("A", A, ma);
    chk("B", B, mb);
    chk("F", F, mf);
    chk("ZF", ZF, mzf);
    chk("OF", OF, mof);
    chk("out", dout, (dbg_addr == 5'd0) ? 32'd0 : mreg[dbg_addr]);
`ifdef OVF_TRAP_EN
    chk("trap", trap, mtrap);
`endif
  end

  function automatic void alu(input logic [31:0] code, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] r, output logic o, output logic il);
    longint s;
    r = 32'd0; o = 1'b0; il = 1'b0;
    case (code[5:0])
      6'h20: begin s = longint'($signed(a)) + longint'($signed(b)); r = a + b; o = (s != longint'($signed(r))); end
      6'h22: begin s = longint'($signed(a)) - longint'($signed(b)); r = a - b; o = (s != longint'($signed(r))); end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h00: r = b << code[10:6];
      6'h02: r = b >> code[10:6];
      default: il = 1'b1;
    endcase
    if (code[31:26] != 6'd0) il = 1'b1;
    if (il) begin r = 32'd0; o = 1'b0; end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    mpc = 0; ma = 0; mb = 0; mf = 0; m_inst = 0;
    mzf = 0; mof = 0; mtrap = 0; exp_ready = 1; exp_ill = 0;
  endtask

  task automatic step();
    @(posedge CLK); #2;
  endtask

  task automatic dbg_write(input logic [4:0] addr, input logic [31:0] val);
    dbg_we = 1'b1; dbg_addr = addr; din = val;
    step();
    dbg_we = 1'b0;
    if (addr != 5'd0) mreg[addr] = val;
  endtask

  // Issue one instruction from IF and follow it to the next IF; optional debug write in WB to rd.
  task automatic run_inst(input logic [31:0] code, input int gap, input bit collide);
    logic [31:0] r, dv;
    logic        o, il, wr;
    repeat (gap) step();
    Inst_code = code; inst_valid = 1'b1;
    step();
    inst_valid = 1'b0; Inst_code = $urandom;
    m_inst = code; exp_ready = 1'b0;
    step();
    ma = mreg[code[25:21]]; mb = mreg[code[20:16]];
    alu(code, ma, mb, r, o, il);
    step();
    mf = r; mzf = (r == 32'd0); mof = o; exp_ill = il;
    dv = $urandom;
    if (collide) begin dbg_we = 1'b1; dbg_addr = code[15:11]; din = dv; end
    step();
    dbg_we = 1'b0; exp_ill = 1'b0; exp_ready = 1'b1;
    if (collide && code[15:11] != 5'd0) mreg[code[15:11]] = dv;
    wr = !il && (code[15:11] != 5'd0);
`ifdef OVF_TRAP_EN
    if (o) begin wr = 1'b0; mtrap = 1'b1; end
`endif
    if (wr) mreg[code[15:11]] = r;
    mpc = mpc + 32'd4;
  endtask

  initial begin
    logic [31:0] f6 [10];
    logic [31:0] code;
    f6 = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h26, 32'h27, 32'h2A, 32'h00, 32'h02, 32'h3F};
    RST = 1'b1; inst_valid = 1'b0; Inst_code = 32'd0;
    dbg_we = 1'b0; dbg_addr = 5'd0; din = 32'd0;

    // 1: reset for two cycles, then sweep the debug read port
    step();
    model_reset(); chk_en = 1'b1;
    step();
    RST = 1'b0;
    chk("rst_pc", PC, 0); chk("rst_F", F, 0); chk("rst_ZF", ZF, 0); chk("rst_OF", OF, 0);
    chk("rst_ready", inst_ready, 1); chk("rst_aluop", ALU_OP, 0);
    for (int i = 0; i < 32; i++) begin dbg_addr = 5'(i); step(); end

    // 2: ADD r3,r1,r2
    dbg_write(5'd1, 32'd5); dbg_write(5'd2, 32'd3);
    run_inst(32'h00221820, 0, 1'b0);
    dbg_addr = 5'd3; #1;
    chk("t2_F", F, 8); chk("t2_ZF", ZF, 0); chk("t2_OF", OF, 0);
    chk("t2_r3", dout, 8); chk("t2_pc", PC, 4);

    // 3: SUB r4,r2,r2 after a 3-cycle fetch stall
    run_inst(32'h00422022, 3, 1'b0);
    dbg_addr = 5'd4; #1;
    chk("t3_F", F, 0); chk("t3_ZF", ZF, 1); chk("t3_r4", dout, 0); chk("t3_pc", PC, 8);

    // 4: signed overflow on ADD r7,r5,r6
    dbg_write(5'd5, 32'h7FFFFFFF); dbg_write(5'd6, 32'd1);
    run_inst(32'h00A63820, 0, 1'b0);
    dbg_addr = 5'd7; #1;
    chk("t4_OF", OF, 1);
`ifdef OVF_TRAP_EN
    chk("t4_r7", dout, 0); chk("t4_trap", trap, 1);
`else
    chk("t4_r7", dout, 32'h80000000);
`endif

    // 5: write to r0 discarded; non-R opcode is illegal but PC advances
    run_inst(32'h00220020, 0, 1'b0);
    dbg_addr = 5'd0; #1;
    chk("t5_r0", dout, 0);
    run_inst(32'h8C220000, 1, 1'b0);
    chk("t5_pc", PC, 20);

    // 6: reset during EX of ADD r3
    dbg_addr = 5'd3;
    Inst_code = 32'h00221820; inst_valid = 1'b1;
    step();
    inst_valid = 1'b0; m_inst = 32'h00221820; exp_ready = 1'b0;
    step();
    ma = mreg[1]; mb = mreg[2]; RST = 1'b1;
    step();
    RST = 1'b0; model_reset();
    chk("t6_pc", PC, 0); chk("t6_ready", inst_ready, 1); chk("t6_r3", dout, 0);

    // Random traffic with boundary operands and WB/debug collisions
    for (int i = 1; i < 32; i++) begin
      case ($urandom_range(0, 5))
        0: dbg_write(5'(i), 32'h7FFFFFFF);
        1: dbg_write(5'(i), 32'h80000000);
        2: dbg_write(5'(i), 32'hFFFFFFFF);
        default: dbg_write(5'(i), $urandom);
      endcase
    end
    for (int n = 0; n < 120; n++) begin
      code = {6'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), f6[$urandom_range(0, 9)][5:0]};
      if ($urandom_range(0, 9) == 0) code[31:26] = 6'($urandom_range(1, 63));
      dbg_addr = 5'($urandom);
      if ($urandom_range(0, 5) == 0) dbg_write(5'($urandom), $urandom);
      run_inst(code, $urandom_range(0, 2), ($urandom_range(0, 4) == 0));
    end

    step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
